// File: rtl/fetch_unit_pkg.sv
// Shared fetch types and processor-wide constants.
// Imported by the fetch stage, its skid buffer and its handshake interface.
package fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam int IMEM_DEPTH_DEF = 128;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t HALT_WORD = '0;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_HALT
  } fstate_t;

  function automatic pc_t wrap_idx(
    input pc_t t,
    input int unsigned depth
  );
    return t % pc_t'(depth);
  endfunction

  function automatic pc_t pc_inc(
    input pc_t pc,
    input int unsigned depth
  );
    return (pc == pc_t'(depth - 1)) ? '0 : pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake.
// The fetch stage drives the master side, decode the slave side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  id_valid;
  logic  id_ready;
  inst_t id_inst;
  pc_t   id_pc;

  modport master (
    output id_valid,
    output id_inst,
    output id_pc,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_inst,
    input  id_pc,
    output id_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a memory response decode could not take.
// Flush beats load, load beats drain.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  load,
  input  logic  drain,
  input  inst_t d_inst,
  input  pc_t   d_pc,
  output logic  full,
  output inst_t q_inst,
  output pc_t   q_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      q_inst <= '0;
      q_pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full   <= 1'b1;
      q_inst <= d_inst;
      q_pc   <= d_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-edge memory response tracking,
// skid buffering toward decode, redirect and halt-on-zero control.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned IMEM_DEPTH   = IMEM_DEPTH_DEF,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  output pc_t       imem_pc,
  input  inst_t     imem_inst,
  input  logic      redir_valid,
  input  pc_t       redir_target,
  output logic      halted,
  fetch_unit_if.master id
);

  pc_t     pc_q;
  logic    f_valid;
  pc_t     f_pc;
  fstate_t state_q;
  fstate_t state_d;

  logic  skid_full;
  inst_t skid_inst;
  pc_t   skid_pc;

  logic  out_valid;
  inst_t out_inst;
  pc_t   out_pc;
  logic  xfer;
  logic  halt_set;
  logic  capture;
  logic  drain;
  logic  issue;
  logic  blocked;

  assign halted  = (state_q == S_HALT);
  assign imem_pc = pc_q;

  // Skid entry is older than anything in flight, so it wins the output.
  always_comb begin
    out_valid = 1'b0;
    out_inst  = '0;
    out_pc    = '0;
    if (skid_full) begin
      out_valid = 1'b1;
      out_inst  = skid_inst;
      out_pc    = skid_pc;
    end else if (f_valid) begin
      out_valid = 1'b1;
      out_inst  = imem_inst;
      out_pc    = f_pc;
    end
  end

  assign id.id_valid = out_valid & ~redir_valid;
  assign id.id_inst  = out_inst;
  assign id.id_pc    = out_pc;

  assign xfer     = id.id_valid & id.id_ready;
  assign halt_set = HALT_ON_ZERO & xfer
                  & (out_inst == HALT_WORD);
  assign blocked  = f_valid & ~id.id_ready;
  assign capture  = blocked & ~skid_full
                  & ~redir_valid;
  assign drain    = skid_full & xfer;
  assign issue    = ~skid_full & ~blocked
                  & ~halted & ~redir_valid
                  & ~halt_set;

  // Memory answers one edge later, so the index travels with f_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= pc_t'(RESET_PC);
      f_valid <= 1'b0;
      f_pc    <= '0;
    end else if (redir_valid) begin
      pc_q    <= wrap_idx(redir_target, IMEM_DEPTH);
      f_valid <= 1'b0;
    end else if (issue) begin
      pc_q    <= pc_inc(pc_q, IMEM_DEPTH);
      f_valid <= 1'b1;
      f_pc    <= pc_q;
    end else begin
      f_valid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redir_valid),
    .load   (capture),
    .drain  (drain),
    .d_inst (imem_inst),
    .d_pc   (f_pc),
    .full   (skid_full),
    .q_inst (skid_inst),
    .q_pc   (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redir_valid) begin
      state_d = S_RUN;
    end else if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (halt_set) begin
      state_d = S_HALT;
    end else if (capture | (skid_full & ~drain)) begin
      state_d = S_STALL;
    end else begin
      state_d = S_RUN;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-edge instruction memory model.
// Program word i holds 32'hA500_0000 + i unless a test plants a zero.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  pc_t   imem_pc;
  inst_t imem_inst;
  logic  redir_valid = 1'b0;
  pc_t   redir_target = '0;
  logic  halted;

  fetch_unit_if id_if ();

  fetch_unit #(
    .RESET_PC     (0),
    .IMEM_DEPTH   (128),
    .HALT_ON_ZERO (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_pc      (imem_pc),
    .imem_inst    (imem_inst),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .halted       (halted),
    .id           (id_if.master)
  );

  always #5 clk = ~clk;

  inst_t mem [128];
  always @(posedge clk) imem_inst <= mem[imem_pc[6:0]];

  int checks = 0;
  int passed = 0;

  function automatic inst_t w(input int i);
    return 32'hA500_0000 + i;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    id_if.id_ready = 1'b1;
    redir_valid = 1'b0;
    redir_target = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    id_if.id_ready = 1'b1;
    #3;
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst, imem_pc, halted}
        !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_state: v=%b pc=%h inst=%h imem_pc=%h halt=%b",
               id_if.id_valid, id_if.id_pc, id_if.id_inst, imem_pc, halted);
    else passed++;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL release_no_valid: v=%b want 0", id_if.id_valid);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd0, w(0)})
      $display("FAIL first_fetch: v=%b pc=%0d inst=%h want 1 0 %h",
               id_if.id_valid, id_if.id_pc, id_if.id_inst, w(0));
    else passed++;
  endtask

  task automatic test_run_to_halt;
    inst_t exp;
    mem[20] = '0;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      step();
      exp = (i == 20) ? 32'h0 : w(i);
      checks++;
      if ({id_if.id_valid, id_if.id_pc, id_if.id_inst, halted}
          !== {1'b1, 32'(i), exp, 1'b0})
        $display("FAIL seq_%0d: v=%b pc=%0d inst=%h halt=%b want pc %0d inst %h",
                 i, id_if.id_valid, id_if.id_pc, id_if.id_inst, halted, i, exp);
      else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({id_if.id_valid, halted, imem_pc} !== {1'b0, 1'b1, 32'd21})
        $display("FAIL halt_%0d: v=%b halt=%b imem_pc=%0d want 0 1 21",
                 k, id_if.id_valid, halted, imem_pc);
      else passed++;
    end
    redir_valid = 1'b1;
    redir_target = 32'd7;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL halt_redir_cycle: v=%b want 0", id_if.id_valid);
    else passed++;
    step();
    redir_valid = 1'b0;
    #1;
    checks++;
    if ({id_if.id_valid, halted} !== {1'b0, 1'b0})
      $display("FAIL halt_cleared: v=%b halt=%b want 0 0",
               id_if.id_valid, halted);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd7, w(7)})
      $display("FAIL halt_restart: v=%b pc=%0d want 1 7",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    mem[20] = w(20);
  endtask

  task automatic test_stall;
    int seq_pc [7] = '{5, 5, 5, 5, -1, 6, 7};
    do_reset();
    repeat (6) step();
    id_if.id_ready = 1'b0;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin
        id_if.id_ready = 1'b1;
        #1;
      end
      checks++;
      if (seq_pc[c] < 0) begin
        if (id_if.id_valid !== 1'b0)
          $display("FAIL stall_bubble: v=%b want 0", id_if.id_valid);
        else passed++;
      end else if ({id_if.id_valid, id_if.id_pc, id_if.id_inst}
                   !== {1'b1, 32'(seq_pc[c]), w(seq_pc[c])})
        $display("FAIL stall_c%0d: v=%b pc=%0d inst=%h want pc %0d",
                 c, id_if.id_valid, id_if.id_pc, id_if.id_inst, seq_pc[c]);
      else passed++;
      if (c < 6) step();
    end
  endtask

  task automatic test_redirect;
    do_reset();
    repeat (5) step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc} !== {1'b1, 32'd4})
      $display("FAIL redir_pre: v=%b pc=%0d want 1 4",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    redir_valid = 1'b1;
    redir_target = 32'd2;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL redir_cycle: v=%b want 0", id_if.id_valid);
    else passed++;
    step();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL redir_gap: v=%b want 0", id_if.id_valid);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd2, w(2)})
      $display("FAIL redir_target: v=%b pc=%0d want 1 2",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd3, w(3)})
      $display("FAIL redir_next: v=%b pc=%0d want 1 3",
               id_if.id_valid, id_if.id_pc);
    else passed++;
  endtask

  task automatic test_wrap;
    int exp_pc [5] = '{125, 126, 127, 0, 1};
    redir_valid = 1'b1;
    redir_target = 32'd125;
    step();
    redir_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({id_if.id_valid, id_if.id_pc, id_if.id_inst}
          !== {1'b1, 32'(exp_pc[k]), w(exp_pc[k])})
        $display("FAIL wrap_%0d: v=%b pc=%0d want %0d",
                 k, id_if.id_valid, id_if.id_pc, exp_pc[k]);
      else passed++;
    end
    redir_valid = 1'b1;
    redir_target = 32'd138;
    step();
    redir_valid = 1'b0;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd10, w(10)})
      $display("FAIL redir_modulo: v=%b pc=%0d want 1 10",
               id_if.id_valid, id_if.id_pc);
    else passed++;
  endtask

  task automatic test_redir_skid;
    do_reset();
    repeat (4) step();
    id_if.id_ready = 1'b0;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc} !== {1'b1, 32'd3})
      $display("FAIL skid_hold: v=%b pc=%0d want 1 3",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    redir_valid = 1'b1;
    redir_target = 32'd50;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL skid_redir_cycle: v=%b want 0", id_if.id_valid);
    else passed++;
    step();
    redir_valid = 1'b0;
    id_if.id_ready = 1'b1;
    #1;
    checks++;
    if (id_if.id_valid !== 1'b0)
      $display("FAIL skid_flushed: v=%b pc=%0d want 0",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd50, w(50)})
      $display("FAIL skid_target: v=%b pc=%0d want 1 50",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc} !== {1'b1, 32'd51})
      $display("FAIL skid_next: v=%b pc=%0d want 1 51",
               id_if.id_valid, id_if.id_pc);
    else passed++;
  endtask

  task automatic test_reset_stall;
    do_reset();
    repeat (3) step();
    id_if.id_ready = 1'b0;
    step();
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc} !== {1'b1, 32'd2})
      $display("FAIL rst_stall_pre: v=%b pc=%0d want 1 2",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst, imem_pc, halted}
        !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL async_reset: v=%b pc=%h inst=%h imem_pc=%h halt=%b",
               id_if.id_valid, id_if.id_pc, id_if.id_inst, imem_pc, halted);
    else passed++;
    step();
    rst_n = 1'b1;
    id_if.id_ready = 1'b1;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc, id_if.id_inst} !== {1'b1, 32'd0, w(0)})
      $display("FAIL rst_restart0: v=%b pc=%0d want 1 0",
               id_if.id_valid, id_if.id_pc);
    else passed++;
    step();
    checks++;
    if ({id_if.id_valid, id_if.id_pc} !== {1'b1, 32'd1})
      $display("FAIL rst_restart1: v=%b pc=%0d want 1 1",
               id_if.id_valid, id_if.id_pc);
    else passed++;
  endtask

  initial begin
    id_if.id_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = w(i);
    test_reset();
    test_run_to_halt();
    test_stall();
    test_redirect();
    test_wrap();
    test_redir_skid();
    test_reset_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
